// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state type, key map and row constants for the keypad scanner
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   // Row drive after reset: row 0 pulled low
   localparam logic [3:0] ROW_RESET = 4'b1110;

   // Entry index is row*4 + column; entry 0 sits in the least significant nibble.
   //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E 0 F D
   localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

   function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
      return KEY_MAP[{r, c, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/keypad_keymap.sv
// rtl/keypad_keymap.sv - (row index, column pattern) to hex code lookup; KEYPAD_MULTIKEY_REJECT_EN rejects multi-column patterns
module keypad_keymap
   import keypad_pkg::*;
(
   input  logic [1:0] row_idx,
   input  logic [3:0] cols,
   output logic [3:0] code,
   output logic       reject
);

   logic [1:0] col_idx;

   // lowest-index set column wins
   always_comb begin
      col_idx = 2'd0;
      if (cols[0])
         col_idx = 2'd0;
      else if (cols[1])
         col_idx = 2'd1;
      else if (cols[2])
         col_idx = 2'd2;
      else if (cols[3])
         col_idx = 2'd3;
   end

   assign code = key_lookup(row_idx, col_idx);

`ifdef KEYPAD_MULTIKEY_REJECT_EN
   // more than one column set looks like a bounce or a chord; refuse it
   assign reject = (cols & (cols - 4'd1)) != 4'd0;
`else
   assign reject = 1'b0;
`endif

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with press/release debounce and one strobe per press
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 4096,
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] col_sync,
   output logic [3:0] row,
   output logic [3:0] key,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int SW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE_CYCLES - 1);

   state_t        state;
   logic [1:0]    r;
   logic [DW-1:0] dwell;
   logic [SW-1:0] stable;
   logic [3:0]    capture;
   logic [3:0]    code;
   logic          reject;

   keypad_keymap u_keymap (
      .row_idx (r),
      .cols    (capture),
      .code    (code),
      .reject  (reject)
   );

   // row drive follows the row index one cycle later
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         row <= ROW_RESET;
      else
         row <= ~(4'b0001 << r);
   end

   // scan, debounce the press, hold, debounce the release
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= SCAN;
         r         <= 2'd0;
         dwell     <= '0;
         stable    <= '0;
         capture   <= 4'h0;
         key       <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         case (state)
            SCAN: begin
               if (dwell == DWELL_LAST) begin
                  dwell <= '0;
                  if (col_sync == 4'h0) begin
                     r <= r + 2'd1;
                  end else begin
                     capture <= col_sync;
                     stable  <= '0;
                     state   <= DEBOUNCE;
                  end
               end else begin
                  dwell <= dwell + DW'(1);
               end
            end
            DEBOUNCE: begin
               if (col_sync != capture || reject) begin
                  state <= SCAN;
                  r     <= r + 2'd1;
               end else if (stable == STABLE_LAST) begin
                  state     <= HELD;
                  key       <= code;
                  key_valid <= 1'b1;
                  key_held  <= 1'b1;
               end else begin
                  stable <= stable + SW'(1);
               end
            end
            HELD: begin
               // other keys on the locked row are ignored; only the captured columns count
               if ((col_sync & capture) == 4'h0) begin
                  state  <= RELEASE;
                  stable <= '0;
               end
            end
            RELEASE: begin
               if (col_sync != 4'h0) begin
                  state <= HELD;
               end else if (stable == STABLE_LAST) begin
                  state    <= SCAN;
                  r        <= r + 2'd1;
                  key_held <= 1'b0;
               end else begin
                  stable <= stable + SW'(1);
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a matrix keypad model
module tb_keypad_scanner;

   localparam int SCAN_DIV        = 4;
   localparam int DEBOUNCE_CYCLES = 8;
   localparam int D               = DEBOUNCE_CYCLES;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] col_sync = 4'h0;
   logic [3:0] row;
   logic [3:0] key;
   logic       key_valid;
   logic       key_held;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;

   int         strobe_cyc[$];
   logic [3:0] strobe_key[$];

   logic [3:0] pressed [4];
   logic [3:0] exp_key;
   logic [3:0] exp_map [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                  '{4'h4, 4'h5, 4'h6, 4'hB},
                                  '{4'h7, 4'h8, 4'h9, 4'hC},
                                  '{4'hE, 4'h0, 4'hF, 4'hD}};

   always #5 clk = ~clk;

   keypad_scanner #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .col_sync  (col_sync),
      .row       (row),
      .key       (key),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   // keypad matrix: a pressed key shorts its column to its row when that row is driven low
   function automatic logic [3:0] cols_for(input logic [3:0] rw);
      logic [3:0] c;
      c = 4'h0;
      for (int i = 0; i < 4; i++)
         if (!rw[i]) c = c | pressed[i];
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cycle++;
      checks++;
      if ($countones(~row) != 1) begin
         errors++;
         $display("FAIL row_onehot cycle %0d: row=%b, required exactly one low bit", cycle, row);
      end
      if (key_valid) begin
         strobe_cyc.push_back(cycle);
         strobe_key.push_back(key);
      end
      col_sync = cols_for(row);
   endtask

   task automatic set_keys(input int r, input logic [3:0] cols);
      pressed[r] = cols;
      col_sync = cols_for(row);
   endtask

   task automatic release_all();
      for (int i = 0; i < 4; i++) pressed[i] = 4'h0;
      col_sync = 4'h0;
   endtask

   task automatic clear_strobes();
      strobe_cyc.delete();
      strobe_key.delete();
   endtask

   // first tick on which the row shows target after not showing it
   task automatic wait_row(input logic [3:0] target, output int ok);
      int n;
      n = 0;
      while (row == target && n < 80) begin tick(); n++; end
      while (row != target && n < 80) begin tick(); n++; end
      ok = (row == target) ? 1 : 0;
      if (ok == 0) begin
         checks++;
         errors++;
         $display("FAIL wait_row timeout: row=%b, required %b", row, target);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (row !== 4'b1110) begin errors++; $display("FAIL reset_row: got %b, required 1110", row); end
      checks++; if (key !== 4'h0) begin errors++; $display("FAIL reset_key: got %h, required 0", key); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b, required 0", key_valid); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_key_held: got %b, required 0", key_held); end
      @(negedge clk);
      reset = 1'b1;
      exp_key = 4'h0;
   endtask

   task automatic test_idle_scan();
      logic [3:0] exp_row;
      for (int k = 1; k <= 16; k++) begin
         tick();
         exp_row = ~(4'b0001 << (((k - 1) / SCAN_DIV) % 4));
         checks++;
         if (row !== exp_row) begin errors++; $display("FAIL idle_row tick %0d: got %b, required %b", k, row, exp_row); end
         checks++;
         if (key_valid !== 1'b0) begin errors++; $display("FAIL idle_key_valid tick %0d: got %b, required 0", k, key_valid); end
      end
   endtask

   task automatic test_press_row2();
      int ok, t0;
      wait_row(4'b1011, ok);
      if (ok == 0) return;
      clear_strobes();
      t0 = cycle;
      set_keys(2, 4'b0010);
      for (int i = 1; i <= 32; i++) begin
         tick();
         if (i == 10) begin
            checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL press8_held_early: got %b, required 0", key_held); end
         end
         if (i == 11) begin
            checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL press8_valid: got %b, required 1", key_valid); end
            checks++; if (key !== 4'h8) begin errors++; $display("FAIL press8_key: got %h, required 8", key); end
            checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press8_held_rise: got %b, required 1", key_held); end
         end
         if (i == 28) begin
            checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press8_held_late: got %b, required 1", key_held); end
         end
         if (i == 29) begin
            checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL press8_held_fall: got %b, required 0", key_held); end
         end
         if (i == 30) begin
            checks++; if (row !== 4'b0111) begin errors++; $display("FAIL press8_next_row: got %b, required 0111", row); end
         end
         if (i == 20) release_all();
      end
      checks++;
      if (strobe_cyc.size() != 1) begin
         errors++; $display("FAIL press8_strobe_count: got %0d, required 1", strobe_cyc.size());
      end else if (strobe_cyc[0] != t0 + 11) begin
         errors++; $display("FAIL press8_latency: got %0d, required %0d", strobe_cyc[0] - t0, 11);
      end
      exp_key = 4'h8;
   endtask

   task automatic test_bounce();
      int ok;
      wait_row(4'b0111, ok);
      if (ok == 0) return;
      clear_strobes();
      set_keys(3, 4'b0001);
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 5) release_all();
         if (i == 6) begin
            checks++; if (row !== 4'b0111) begin errors++; $display("FAIL bounce_row_hold: got %b, required 0111", row); end
         end
         if (i == 7) begin
            checks++; if (row !== 4'b1110) begin errors++; $display("FAIL bounce_row_resume: got %b, required 1110", row); end
         end
      end
      checks++; if (strobe_cyc.size() != 0) begin errors++; $display("FAIL bounce_strobe_count: got %0d, required 0", strobe_cyc.size()); end
      checks++; if (key !== exp_key) begin errors++; $display("FAIL bounce_key_kept: got %h, required %h", key, exp_key); end
   endtask

   task automatic test_glitch();
      int ok, t0, bad;
      wait_row(4'b1101, ok);
      if (ok == 0) return;
      clear_strobes();
      t0 = cycle;
      bad = 0;
      set_keys(1, 4'b1000);
      for (int i = 1; i <= 45; i++) begin
         tick();
         if (i >= 11 && i <= 30 + D && key_held !== 1'b1) bad++;
         if (i == 30 + D + 1) begin
            checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL glitch_held_fall: got %b, required 0", key_held); end
         end
         if (i == 15) release_all();
         if (i == 18) set_keys(1, 4'b1000);
         if (i == 30) release_all();
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL glitch_held_stays: got %0d low cycles, required 0", bad); end
      checks++;
      if (strobe_cyc.size() != 1) begin
         errors++; $display("FAIL glitch_strobe_count: got %0d, required 1", strobe_cyc.size());
      end else if (strobe_key[0] !== 4'hB || strobe_cyc[0] != t0 + 11) begin
         errors++; $display("FAIL glitch_strobe: got key %h at %0d, required B at %0d", strobe_key[0], strobe_cyc[0] - t0, 11);
      end
      exp_key = 4'hB;
   endtask

   task automatic test_multikey();
      int ok, t0;
      wait_row(4'b1110, ok);
      if (ok == 0) return;
      clear_strobes();
      t0 = cycle;
      set_keys(0, 4'b0101);
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (i == 20) release_all();
      end
`ifdef KEYPAD_MULTIKEY_REJECT_EN
      checks++; if (strobe_cyc.size() != 0) begin errors++; $display("FAIL multikey_reject_count: got %0d, required 0", strobe_cyc.size()); end
      checks++; if (key !== exp_key) begin errors++; $display("FAIL multikey_reject_key: got %h, required %h", key, exp_key); end
`else
      checks++;
      if (strobe_cyc.size() != 1) begin
         errors++; $display("FAIL multikey_count: got %0d, required 1", strobe_cyc.size());
      end else if (strobe_key[0] !== 4'h1 || strobe_cyc[0] != t0 + 11) begin
         errors++; $display("FAIL multikey_strobe: got key %h at %0d, required 1 at %0d", strobe_key[0], strobe_cyc[0] - t0, 11);
      end
      exp_key = 4'h1;
`endif
   endtask

   task automatic test_reset_in_debounce();
      int ok;
      wait_row(4'b1011, ok);
      if (ok == 0) return;
      set_keys(2, 4'b0100);
      repeat (5) tick();
      #2;
      reset = 1'b0;
      #1;
      checks++; if (row !== 4'b1110) begin errors++; $display("FAIL async_reset_row: got %b, required 1110", row); end
      checks++; if (key !== 4'h0) begin errors++; $display("FAIL async_reset_key: got %h, required 0", key); end
      checks++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin
         errors++; $display("FAIL async_reset_flags: got valid=%b held=%b, required 0 0", key_valid, key_held);
      end
      exp_key = 4'h0;
      release_all();
      @(negedge clk);
      reset = 1'b1;
      clear_strobes();
      repeat (30) tick();
      checks++; if (strobe_cyc.size() != 0) begin errors++; $display("FAIL async_reset_no_strobe: got %0d, required 0", strobe_cyc.size()); end
   endtask

   task automatic test_random();
      int r, c, hold, tp, tr, fall, lat;
      for (int ep = 0; ep < 10; ep++) begin
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         clear_strobes();
         tp = cycle;
         set_keys(r, 4'b0001 << c);
         if ($urandom_range(0, 1) == 1) begin
            hold = $urandom_range(30, 50);
            repeat (hold) tick();
            release_all();
            tr = cycle;
            fall = -1;
            for (int j = 1; j <= 40; j++) begin
               tick();
               if (!key_held) begin fall = cycle - tr; break; end
            end
            repeat (3) tick();
            checks++;
            if (strobe_cyc.size() != 1) begin
               errors++; $display("FAIL rand_long_count ep %0d: got %0d, required 1", ep, strobe_cyc.size());
            end else begin
               lat = strobe_cyc[0] - tp;
               if (strobe_key[0] !== exp_map[r][c]) begin
                  errors++; $display("FAIL rand_long_key ep %0d: got %h, required %h", ep, strobe_key[0], exp_map[r][c]);
               end else if (lat < D + 1 || lat > D + 4 * SCAN_DIV) begin
                  errors++; $display("FAIL rand_long_latency ep %0d: got %0d, required %0d..%0d", ep, lat, D + 1, D + 4 * SCAN_DIV);
               end
               exp_key = exp_map[r][c];
            end
            checks++;
            if (fall != D + 1) begin errors++; $display("FAIL rand_long_release ep %0d: got %0d, required %0d", ep, fall, D + 1); end
         end else begin
            hold = $urandom_range(1, D);
            repeat (hold) tick();
            release_all();
            repeat (4) tick();
            checks++;
            if (strobe_cyc.size() != 0 || key !== exp_key) begin
               errors++; $display("FAIL rand_short ep %0d: got %0d strobes key %h, required 0 strobes key %h", ep, strobe_cyc.size(), key, exp_key);
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4; i++) pressed[i] = 4'h0;
      exp_key = 4'h0;
      test_reset();
      test_idle_scan();
      test_press_row2();
      test_bounce();
      test_glitch();
      test_multikey();
      test_reset_in_debounce();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
